tpu_cmd_seq: RTL and testbench

- Parametrised command sequencer placed between the host and the TPU top level.
- Replaces the host-driven static UB-read, systolic-switch, mode and VPU-pathway lines with a queued command stream.
- Issues each command as a one-cycle UB read start with the address and size fields held stable.
- Tracks completion by counting VPU valid beats; lane count, queue depth and size widths are generic.

---
 rtl/tpu_cmd_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_tpu_cmd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tpu_cmd_seq.sv
// Queued command sequencer driving the TPU UB-read, systolic-switch, mode and VPU-pathway lines.
// Optional watchdog on the wait states: define TPU_CMD_SEQ_WATCHDOG_EN.
module tpu_cmd_seq #(
  parameter int unsigned N           = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DIM_W       = 16,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [8:0]       cmd_ptr_sel,
  input  logic [DIM_W-1:0] cmd_addr,
  input  logic [DIM_W-1:0] cmd_rows,
  input  logic [DIM_W-1:0] cmd_cols,
  input  logic             cmd_transpose,
  input  logic [3:0]       cmd_pathway,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_flush,
  input  logic [N-1:0]     vpu_valid_in,
  output logic             ub_rd_start_in,
  output logic             ub_rd_transpose,
  output logic [8:0]       ub_ptr_select,
  output logic [DIM_W-1:0] ub_rd_addr_in,
  output logic [DIM_W-1:0] ub_rd_row_size,
  output logic [DIM_W-1:0] ub_rd_col_size,
  output logic             sys_switch_in,
  output logic [1:0]       sys_mode,
  output logic [3:0]       vpu_data_pathway,
  output logic             busy,
  output logic             done,
  output logic             err_stray,
  output logic             err_illegal,
  output logic             err_timeout
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CNTW = DIM_W + 1;
  localparam int unsigned EW   = 19 + 3 * DIM_W;

  localparam logic [2:0] OpNop     = 3'd0;
  localparam logic [2:0] OpLoadW   = 3'd1;
  localparam logic [2:0] OpRun     = 3'd2;
  localparam logic [2:0] OpSwitch  = 3'd3;
  localparam logic [2:0] OpSetMode = 3'd4;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWaitW   = 3'd2;
  localparam logic [2:0] StWaitRun = 3'd3;
  localparam logic [2:0] StRetire  = 3'd4;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            push, pop, wd_expire;

  logic [2:0]       h_op;
  logic [8:0]       h_ptr;
  logic [DIM_W-1:0] h_addr, h_rows, h_cols;
  logic             h_tr;
  logic [3:0]       h_path;
  logic [1:0]       h_mode;

  logic [2:0]       cur_op_q;
  logic [DIM_W-1:0] cur_rows_q;
  logic [3:0]       cur_path_q;
  logic [1:0]       cur_mode_q;

  logic ready_q, busy_q, done_q, start_q, switch_q, stray_q, illegal_q;

  assign push = cmd_valid && ready_q && !cmd_flush;
  assign pop  = (state_q == StIdle) && (count_q != '0) && !cmd_flush;
  assign {h_op, h_ptr, h_addr, h_rows, h_cols, h_tr, h_path, h_mode} = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (cmd_flush) count_d = '0;
  end

`ifdef TPU_CMD_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);
  logic [WdW-1:0] wd_q;
  logic           timeout_q;

  assign wd_expire   = ((state_q == StWaitW) || (state_q == StWaitRun)) &&
                       (wd_q == WdW'(WDOG_CYCLES - 1));
  assign err_timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == StWaitW) || (state_q == StWaitRun)) wd_q <= wd_q + WdW'(1);
      else                                                 wd_q <= '0;
      if (cmd_flush)      timeout_q <= 1'b0;
      else if (wd_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Counter widths leave one spare bit so rows + N never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          case (h_op)
            OpNop:             state_d = StRetire;
            OpLoadW, OpRun:    state_d = (h_rows == '0) ? StRetire : StIssue;
            OpSwitch, OpSetMode: state_d = StIssue;
            default:           state_d = StRetire;
          endcase
        end
      end
      StIssue: begin
        cnt_d = '0;
        if (cur_op_q == OpLoadW)   state_d = StWaitW;
        else if (cur_op_q == OpRun) state_d = StWaitRun;
        else                        state_d = StRetire;
      end
      StWaitW: begin
        if (wd_expire || (cnt_q + CNTW'(1) == {1'b0, cur_rows_q} + CNTW'(N))) state_d = StRetire;
        else cnt_d = cnt_q + CNTW'(1);
      end
      StWaitRun: begin
        if (wd_expire) state_d = StRetire;
        else if (vpu_valid_in[0]) begin
          if (cnt_q + CNTW'(1) == {1'b0, cur_rows_q}) state_d = StRetire;
          else cnt_d = cnt_q + CNTW'(1);
        end
      end
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (cmd_flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_ptr_sel, cmd_addr, cmd_rows, cmd_cols,
                                  cmd_transpose, cmd_pathway, cmd_mode};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      state_q          <= StIdle;
      cnt_q            <= '0;
      cur_op_q         <= OpNop;
      cur_rows_q       <= '0;
      cur_path_q       <= '0;
      cur_mode_q       <= '0;
      ready_q          <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      start_q          <= 1'b0;
      switch_q         <= 1'b0;
      stray_q          <= 1'b0;
      illegal_q        <= 1'b0;
      ub_rd_transpose  <= 1'b0;
      ub_ptr_select    <= '0;
      ub_rd_addr_in    <= '0;
      ub_rd_row_size   <= '0;
      ub_rd_col_size   <= '0;
      sys_mode         <= '0;
      vpu_data_pathway <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
      if (cmd_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (pop) begin
        cur_op_q   <= h_op;
        cur_rows_q <= h_rows;
        cur_path_q <= h_path;
        cur_mode_q <= h_mode;
        if ((h_op == OpLoadW) || (h_op == OpRun)) begin
          ub_rd_transpose <= h_tr;
          ub_ptr_select   <= h_ptr;
          ub_rd_addr_in   <= h_addr;
          ub_rd_row_size  <= h_rows;
          ub_rd_col_size  <= h_cols;
        end
      end
      busy_q   <= !cmd_flush && ((state_q != StIdle) || (count_q != '0));
      done_q   <= !cmd_flush && (state_q == StRetire);
      start_q  <= !cmd_flush && (state_q == StIssue) &&
                  ((cur_op_q == OpLoadW) || (cur_op_q == OpRun));
      switch_q <= !cmd_flush && (state_q == StIssue) && (cur_op_q == OpSwitch);
      if (!cmd_flush && (state_q == StIssue) && (cur_op_q == OpSetMode)) begin
        sys_mode         <= cur_mode_q;
        vpu_data_pathway <= cur_path_q;
      end
      if (cmd_flush)                                        stray_q <= 1'b0;
      else if ((|vpu_valid_in) && (state_q != StWaitRun))   stray_q <= 1'b1;
      if (cmd_flush)                 illegal_q <= 1'b0;
      else if (pop && (h_op > OpSetMode)) illegal_q <= 1'b1;
    end
  end

  assign cmd_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ub_rd_start_in = start_q;
  assign sys_switch_in  = switch_q;
  assign err_stray      = stray_q;
  assign err_illegal    = illegal_q;

endmodule

// File: tb/tb_tpu_cmd_seq.sv
// Directed bench for tpu_cmd_seq; cycle k means just after rising edge k (push edge = 0).
module tb_tpu_cmd_seq;
  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_transpose, cmd_flush;
  logic [2:0]  cmd_op;
  logic [8:0]  cmd_ptr_sel;
  logic [15:0] cmd_addr, cmd_rows, cmd_cols;
  logic [3:0]  cmd_pathway;
  logic [1:0]  cmd_mode;
  logic [1:0]  vpu_valid_in;
  logic        ub_rd_start_in, ub_rd_transpose, sys_switch_in, busy, done;
  logic [8:0]  ub_ptr_select;
  logic [15:0] ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size;
  logic [1:0]  sys_mode;
  logic [3:0]  vpu_data_pathway;
  logic        err_stray, err_illegal, err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  tpu_cmd_seq #(.N(2), .DEPTH(8), .DIM_W(16), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ptr_sel(cmd_ptr_sel), .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
    .cmd_cols(cmd_cols), .cmd_transpose(cmd_transpose), .cmd_pathway(cmd_pathway),
    .cmd_mode(cmd_mode), .cmd_flush(cmd_flush), .vpu_valid_in(vpu_valid_in),
    .ub_rd_start_in(ub_rd_start_in), .ub_rd_transpose(ub_rd_transpose),
    .ub_ptr_select(ub_ptr_select), .ub_rd_addr_in(ub_rd_addr_in),
    .ub_rd_row_size(ub_rd_row_size), .ub_rd_col_size(ub_rd_col_size),
    .sys_switch_in(sys_switch_in), .sys_mode(sys_mode),
    .vpu_data_pathway(vpu_data_pathway), .busy(busy), .done(done),
    .err_stray(err_stray), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one command; returns just after the accepting edge (cycle 0).
  task automatic push_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] rows,
                          input logic [15:0] cols, input logic [3:0] pw, input logic [1:0] md);
    cmd_op = op; cmd_addr = addr; cmd_rows = rows; cmd_cols = cols;
    cmd_pathway = pw; cmd_mode = md; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_ptr_sel = 0; cmd_addr = 0; cmd_rows = 0;
    cmd_cols = 0; cmd_transpose = 0; cmd_pathway = 0; cmd_mode = 0; cmd_flush = 0;
    vpu_valid_in = 0;
    tickn(2);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", ub_rd_start_in, 0);
    check("rst_mode", sys_mode, 0);
    rst = 1'b0;
    tick();

    // NOP
    push_cmd(3'd0, 0, 0, 0, 0, 0);
    tick(); check("nop_done_t1", done, 0); check("nop_busy_t1", busy, 1);
    tick(); check("nop_done_t2", done, 1);
    tick(); check("nop_done_t3", done, 0); check("nop_busy_t3", busy, 0);
    check("nop_errs", {29'd0, err_stray, err_illegal, err_timeout}, 0);
    tick();

    // SET_MODE then RUN with three lane-0 beats
    push_cmd(3'd4, 0, 0, 0, 4'b1011, 2'd2);
    cmd_ptr_sel = 9'h1a5; cmd_transpose = 1'b1;
    push_cmd(3'd2, 16'h0010, 16'd3, 16'd2, 0, 0);
    cmd_ptr_sel = 0; cmd_transpose = 0;
    tick(); tick();
    check("set_mode", sys_mode, 2); check("set_path", vpu_data_pathway, 4'b1011);
    check("set_done", done, 1);
    tick(); check("run_start_c4", ub_rd_start_in, 0);
    tick(); check("run_start_c5", ub_rd_start_in, 1);
    check("run_addr", ub_rd_addr_in, 16'h10); check("run_rows", ub_rd_row_size, 3);
    check("run_cols", ub_rd_col_size, 2); check("run_ptr", ub_ptr_select, 9'h1a5);
    check("run_tr", ub_rd_transpose, 1);
    tick(); check("run_start_c6", ub_rd_start_in, 0);
    vpu_valid_in = 2'b01;
    tickn(3); vpu_valid_in = 2'b00;
    check("run_done_c9", done, 0);
    tick(); check("run_done_c10", done, 1); check("run_mode_kept", sys_mode, 2);
    tick(); check("run_done_c11", done, 0); check("run_stray", err_stray, 0);
    tick();

    // LOAD_W rows=4, SWITCH queued behind
    push_cmd(3'd1, 16'h0040, 16'd4, 16'd4, 0, 0);
    push_cmd(3'd3, 0, 0, 0, 0, 0);
    check("ldw_start_c1", ub_rd_start_in, 0);
    tick(); check("ldw_start_c2", ub_rd_start_in, 1);
    tick(); check("ldw_start_c3", ub_rd_start_in, 0);
    tickn(5); check("ldw_done_c8", done, 0);
    tick(); check("ldw_done_c9", done, 1);
    tick(); check("sw_c10", sys_switch_in, 0);
    tick(); check("sw_c11", sys_switch_in, 1);
    tick(); check("sw_c12", sys_switch_in, 0); check("sw_done_c12", done, 1);
    tick();

    // RUN rows=0 skips the start pulse
    push_cmd(3'd2, 16'h0020, 16'd0, 16'd5, 0, 0);
    pulses = 0;
    tick(); pulses += int'(ub_rd_start_in); check("r0_done_c1", done, 0);
    tick(); pulses += int'(ub_rd_start_in); check("r0_done_c2", done, 1);
    tick(); pulses += int'(ub_rd_start_in);
    check("r0_no_start", pulses, 0); check("r0_addr", ub_rd_addr_in, 16'h20);

    // Fill FIFO behind a blocked RUN, then flush
    push_cmd(3'd2, 0, 16'd2, 16'd1, 0, 0);
    tickn(3);
    cmd_op = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) check("fill_ready_7", cmd_ready, 1);
    end
    check("fill_ready_8", cmd_ready, 0);
    tick(); check("fill_ready_9", cmd_ready, 0); check("fill_busy", busy, 1);
    cmd_flush = 1'b1;
    tick(); cmd_flush = 1'b0; cmd_valid = 1'b0;
    check("flush_ready", cmd_ready, 1); check("flush_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); pulses += int'(done) + int'(ub_rd_start_in);
    end
    check("flush_no_done", pulses, 0); check("flush_idle_busy", busy, 0);
    check("flush_mode_kept", sys_mode, 2);

    // Stray valid in IDLE, illegal op
    vpu_valid_in = 2'b10;
    tick(); vpu_valid_in = 2'b00;
    check("stray_set", err_stray, 1);
    tickn(2); check("stray_held", err_stray, 1);
    push_cmd(3'd6, 0, 0, 0, 0, 0);
    tick(); check("ill_set", err_illegal, 1);
    tick(); check("ill_done", done, 1); check("stray_held2", err_stray, 1);
    tick();
    cmd_flush = 1'b1; tick(); cmd_flush = 1'b0;
    check("stray_clr", err_stray, 0); check("ill_clr", err_illegal, 0);
    tick();

    // RUN rows=5 with no beats
    push_cmd(3'd2, 0, 16'd5, 16'd1, 0, 0);
`ifdef TPU_CMD_SEQ_WATCHDOG_EN
    tickn(17); check("wd_to_c17", err_timeout, 0); check("wd_done_c17", done, 0);
    tick(); check("wd_to_c18", err_timeout, 1);
    tick(); check("wd_done_c19", done, 1);
    cmd_flush = 1'b1; tick(); cmd_flush = 1'b0;
    check("wd_to_clr", err_timeout, 0);
`else
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); pulses += int'(done);
    end
    check("nowd_busy", busy, 1); check("nowd_no_done", pulses, 0);
    check("nowd_to", err_timeout, 0);
    cmd_flush = 1'b1; tick(); cmd_flush = 1'b0;
`endif
    tick();

    // Reset in the middle of a LOAD_W, late VPU beat afterwards
    push_cmd(3'd1, 16'h0077, 16'd10, 16'd3, 0, 0);
    tickn(4);
    check("mid_rows", ub_rd_row_size, 10);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0); check("mid_rst_rows", ub_rd_row_size, 0);
    check("mid_rst_ready", cmd_ready, 1);
    tick(); rst = 1'b0;
    vpu_valid_in = 2'b01;
    tick(); vpu_valid_in = 2'b00;
    check("mid_rst_stray", err_stray, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
